// File: rtl/traffic_light_ped_if.sv
// traffic_light_ped_if
//   Groups the tick/request inputs and the lamp/status outputs of the
//   intersection controller into one bundle.
//   master : environment side (drives tick/ped_req, observes lamps/status)
//   slave  : controller side  (observes tick/ped_req, drives lamps/status)
//   Signals:
//     tick        1-cycle per-second pulse from the shared prescaler
//     ped_req     pedestrian button (level or pulse)
//     ns_g/y/r    north-south lamps
//     ew_g/y/r    east-west lamps
//     walk        pedestrian walk lamp
//     ped_pending latched pedestrian request
//     phase       current state code
interface traffic_light_ped_if;
  logic       tick;
  logic       ped_req;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, ped_req,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
  );

  modport slave (
    input  tick, ped_req,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_light_ped.sv
// traffic_light_ped
//   Two-road intersection controller with configurable phase durations,
//   optional all-red clearance and a latched pedestrian walk phase.
//   Advances only on the 1-cycle tick pulse; all lamps are Moore outputs.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    traffic_light_ped_if.slave (tick, ped_req in; lamps, walk,
//            ped_pending, phase out)
//
//   state | meaning
//   ------+-----------------------------------------------
//   NS_G  | north-south green, east-west red      (code 0)
//   NS_Y  | north-south yellow, east-west red     (code 1)
//   AR_A  | all red clearance before EW green     (code 2)
//   EW_G  | east-west green, north-south red      (code 3)
//   EW_Y  | east-west yellow, north-south red     (code 4)
//   AR_B  | all red clearance before NS/PED       (code 5)
//   PED   | all red, pedestrian walk lit         (code 6)
//   (code 7 is unused and returns to NS_G on the next clk)
module traffic_light_ped #(
  parameter int unsigned GREEN_TICKS  = 5,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned PED_TICKS    = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ped_if.slave   bus
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    PED  = 3'd6
  } state_t;

  // Terminal counts (duration - 1). The all-red value is clamped so the
  // constant stays in range when clearance is disabled; those states are
  // then unreachable anyway.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST =
    CNT_W'((ALLRED_TICKS > 0) ? (ALLRED_TICKS - 1) : 0);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_TICKS - 1);
  localparam bit               SKIP_ALLRED = (ALLRED_TICKS == 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic [CNT_W-1:0] last_cnt;
  logic             at_end;
  state_t           succ;
  logic             ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= NS_G;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    last_cnt = '0;
    unique case (state_q)
      NS_G, EW_G: last_cnt = GREEN_LAST;
      NS_Y, EW_Y: last_cnt = YELLOW_LAST;
      AR_A, AR_B: last_cnt = ALLRED_LAST;
      PED:        last_cnt = PED_LAST;
      default:    last_cnt = '0;
    endcase
  end

  assign at_end = bus.tick && (cnt_q == last_cnt);

  // Successor state when the current dwell expires. The pedestrian decision
  // uses the registered request, so a press on the exit clk itself waits
  // for the next cycle.
  always_comb begin
    succ = NS_G;
    unique case (state_q)
      NS_G: succ = NS_Y;
      NS_Y: succ = SKIP_ALLRED ? EW_G : AR_A;
      AR_A: succ = EW_G;
      EW_G: succ = EW_Y;
      EW_Y: begin
        if (SKIP_ALLRED) succ = ped_pending_q ? PED : NS_G;
        else             succ = AR_B;
      end
      AR_B: succ = ped_pending_q ? PED : NS_G;
      PED:  succ = NS_G;
      default: succ = NS_G;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!(state_q inside {NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B, PED})) begin
      state_d = NS_G;
      cnt_d   = '0;
    end else if (at_end) begin
      state_d = succ;
      cnt_d   = '0;
    end else if (bus.tick) begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Entering PED clears the latch and takes priority over a press on the
  // same clk; presses while in PED are dropped.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == PED) && (state_q != PED)) begin
      ped_pending_d = 1'b0;
    end else if (bus.ped_req && (state_q != PED)) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b0;
    walk = 1'b0;
    unique case (state_q)
      NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
      PED:  begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign bus.ns_g        = ns_g;
  assign bus.ns_y        = ns_y;
  assign bus.ns_r        = ns_r;
  assign bus.ew_g        = ew_g;
  assign bus.ew_y        = ew_y;
  assign bus.ew_r        = ew_r;
  assign bus.walk        = walk;
  assign bus.ped_pending = ped_pending_q;
  assign bus.phase       = state_q;

endmodule
